// File: rtl/block_accumulator_wprecision.sv
// Block accumulator: sums a programmable number of fixed-point samples and
// reports, with each sum, how many bits of o_data actually carry information.
module block_accumulator_wprecision #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_ACC = 32,
    parameter int LEN_WIDTH = 8,
    parameter int IS_SIGNED = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ena,
    input  logic                 i_valid,
    input  logic [WIDTH_IN-1:0]  i_data,
    input  logic [LEN_WIDTH-1:0] i_block_len,
    input  logic                 i_flush,
    output logic                 o_valid,
    output logic [WIDTH_ACC-1:0] o_data,
    output logic [7:0]           o_current_precision,
    output logic                 o_partial,
    output logic                 o_busy
);

    if ((WIDTH_IN + LEN_WIDTH > WIDTH_ACC) || (WIDTH_ACC > 255)) begin : g_param_check
        $error("block_accumulator_wprecision: need WIDTH_IN + LEN_WIDTH <= WIDTH_ACC <= 255");
    end

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH_ACC-1:0] acc_q, acc_d;
    logic [WIDTH_ACC-1:0] data_q, data_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [7:0]           prec_q, prec_d;
    logic                 valid_q, valid_d;
    logic                 partial_q, partial_d;
    logic                 busy_q, busy_d;

    logic                 s;
    logic                 f;
    logic                 sign_bit;
    logic [WIDTH_ACC-1:0] sample_ext;
    logic [WIDTH_ACC-1:0] acc_sum;
    logic [LEN_WIDTH-1:0] cnt_inc;
    logic [LEN_WIDTH-1:0] len_eff;

    // Bit-length of (n-1) added to the sample width, clamped to the output width.
    function automatic logic [7:0] precision(input logic [LEN_WIDTH-1:0] n);
        logic [LEN_WIDTH-1:0] m;
        logic [7:0]           bits;
        int                   p;
        m    = n - LEN_WIDTH'(1);
        bits = '0;
        for (int unsigned i = 0; i < LEN_WIDTH; i++) begin
            if (m[i]) begin
                bits = 8'(i + 1);
            end
        end
        p = WIDTH_IN + int'(bits);
        if (p > WIDTH_ACC) begin
            p = WIDTH_ACC;
        end
        return 8'(p);
    endfunction

    assign s          = i_ena & i_valid;
    assign f          = i_ena & i_flush;
    assign sign_bit   = (IS_SIGNED != 0) & i_data[WIDTH_IN-1];
    assign sample_ext = {{(WIDTH_ACC-WIDTH_IN){sign_bit}}, i_data};
    assign acc_sum    = acc_q + sample_ext;
    assign cnt_inc    = cnt_q + LEN_WIDTH'(1);
    assign len_eff    = (i_block_len == '0) ? LEN_WIDTH'(1) : i_block_len;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        prec_d    = prec_q;
        partial_d = partial_q;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    len_d = len_eff;
                    acc_d = sample_ext;
                    cnt_d = LEN_WIDTH'(1);
                    if ((len_eff == LEN_WIDTH'(1)) || i_flush) begin
                        valid_d   = 1'b1;
                        data_d    = sample_ext;
                        prec_d    = precision(LEN_WIDTH'(1));
                        partial_d = (len_eff != LEN_WIDTH'(1));
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (s) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    if ((cnt_inc == len_q) || i_flush) begin
                        valid_d   = 1'b1;
                        data_d    = acc_sum;
                        prec_d    = precision(cnt_inc);
                        partial_d = (cnt_inc != len_q);
                        state_d   = IDLE;
                    end
                end else if (f) begin
                    valid_d   = 1'b1;
                    data_d    = acc_q;
                    prec_d    = precision(cnt_q);
                    partial_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ACCUM);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            prec_q    <= '0;
            valid_q   <= 1'b0;
            partial_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            prec_q    <= prec_d;
            valid_q   <= valid_d;
            partial_q <= partial_d;
            busy_q    <= busy_d;
        end
    end

    assign o_valid             = valid_q;
    assign o_data              = data_q;
    assign o_current_precision = prec_q;
    assign o_partial           = partial_q;
    assign o_busy              = busy_q;

endmodule

// File: doc/block_accumulator_wprecision.md
# block_accumulator_wprecision

Accumulates a programmable number of fixed-point samples into a wide sum and reports, with each sum, the number of bits that actually carry information. It sits directly upstream of the unbiased rounding stage with current-precision input. Its `o_data` and `o_current_precision` drive that stage's `i_data` and `i_current_precision`, so the rounder's output stays correctly scaled for any block length.

## Interface
- `WIDTH_IN`, default 16: sample width.
- `WIDTH_ACC`, default 32: accumulator and output width. Must satisfy `WIDTH_IN + LEN_WIDTH <= WIDTH_ACC <= 255`; otherwise `$error` at elaboration.
- `LEN_WIDTH`, default 8: width of the block-length input.
- `IS_SIGNED`, default 1: 1 = two's complement, 0 = unsigned.
- Clock and reset: one clock; reset is synchronous and active-high.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous active-high reset.
- `i_ena`  in  1  global enable. When low, all state and outputs freeze and `o_valid` is driven 0.
- `i_valid`  in  1  `i_data` carries a sample this cycle.
- `i_data`  in  `WIDTH_IN`  sample.
- `i_block_len`  in  `LEN_WIDTH`  samples per block. Latched on the first sample of each block; 0 is treated as 1.
- `i_flush`  in  1  terminate the current block early and emit the partial sum.
- `o_valid`  out  1  one-cycle pulse: sum outputs updated.
- `o_data`  out  `WIDTH_ACC`  block sum, sign-extended (signed) or zero-extended (unsigned).
- `o_current_precision`  out  8  valid bit-width of `o_data`.
- `o_partial`  out  1  the emitted sum came from a flush before the block length was reached.
- `o_busy`  out  1  a block is open (state `ACCUM`).

## Operation
- **States:** `IDLE`, `ACCUM`.
- **Internal registers:** `acc[WIDTH_ACC]`, `cnt[LEN_WIDTH]`, `len_q[LEN_WIDTH]`.
- **Qualified sample:** `s = i_ena & i_valid`. Samples are extended per `IS_SIGNED` before addition.
- **IDLE, on `s`:**
  - `len_q <= max(i_block_len, 1)`; `acc <= ext(i_data)`; `cnt <= 1`.
  - If the length is 1, or `i_flush` is high, emit immediately and stay in `IDLE`.
  - Otherwise go to `ACCUM`.
- **IDLE, `i_flush` without `s`:** ignored.
- **ACCUM, on `s`:**
  - `acc <= acc + ext(i_data)`; `cnt <= cnt + 1`.
  - If `cnt + 1 == len_q`, emit with `o_partial = 0` and go to `IDLE`.
- **ACCUM, on `i_flush`:**
  - Emit `acc` (plus the sample, if `s` in the same cycle) with `o_partial = 1` and go to `IDLE`.
  - If the simultaneous sample completes the block, `o_partial = 0`.
- **Emit:** `o_data <=` the final sum; `o_current_precision <= WIDTH_IN + clog2(N)`, where N is the number of samples actually summed.
  - `clog2(N)` is the bit-length of `N-1`: N=1→0, 2→1, 3→2, 4→2, 5→3, 255→8.
  - Result is clamped to `WIDTH_ACC` (never exceeded under the parameter rule).
- **No overflow:** the parameter rule guarantees the sum of N samples fits in `WIDTH_IN + clog2(N)` bits, so the block has no saturation logic.
- **Mid-block length changes:** a change on `i_block_len` while in `ACCUM` is ignored until the next block.
- **Output hold:** `o_data`, `o_current_precision` and `o_partial` hold their values between pulses.

## Timing
- **Reset values:** `o_valid=0`, `o_data=0`, `o_current_precision=0`, `o_partial=0`, `o_busy=0`, state `IDLE`, internal registers 0.
- **Reset mid-block:** discards the partial sum with no emit.
- **Latency:** `o_valid` rises exactly 1 cycle after the cycle containing the final (or flushing) sample.
- **Throughput:** one sample per cycle, no bubble between blocks. A sample arriving in the cycle after a block completes opens the next block. Length-1 blocks give a pulse every cycle.
- **`o_busy`:** registered; high from the cycle after the first sample of a block with length greater than 1, until the cycle after completion.
- **`i_ena` low:** `i_valid` and `i_flush` are ignored, counters hold, and `o_valid=0` on the following cycle.
- **Downstream handshake:** none. The downstream rounder uses `o_valid` as its `i_ena`, and has 1 further cycle of delay.

## Test plan
1. Signed defaults, `len=4`, samples 100, −50, 200, 7 → one cycle after the 4th sample: `o_valid=1`, `o_data=257`, precision 18, `o_partial=0`, `o_busy` falls.
2. Lengths 1 and 0, samples 5 then −3 on back-to-back cycles → two consecutive pulses: `o_data=5` then `0xFFFFFFFD`, precision 16 each.
3. `len=255`, every sample −32768 → `o_data=−8355840` (`0xFF808000`), precision 24, no wrap.
4. `len=8`, samples 10, 20, 30, then `i_flush` alone → `o_data=60`, precision 18, `o_partial=1`. The next sample opens a fresh block.
5. `len=4`: 2 samples, then `i_ena` low for 5 cycles with `i_valid=1` (values ignored), then 2 more samples 1, 1 → sum counts only 4 samples. Then assert `i_rst` after 2 samples of a new block → all outputs 0, no pulse, and the next block sums cleanly.
6. `IS_SIGNED=0`, `len=3`, samples 0xFFFF ×3 → `o_data=196605`, precision 18.
